// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants for the decode control pipeline.
// Holds opcode values, ALUOp and forward-select encodings, and the
// size of the per-instruction control bundle.
package ctrl_pipe_pkg;

  // Base opcodes of the instruction classes that drive decode
  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // Operand forward selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Single-bit decode controls: alu_src, branch, jump, mem_read,
  // mem_write, mem_2_reg, reg_write
  localparam int CTRL_BITS = 7;
  // valid + ALUOp + single-bit controls
  localparam int CTRL_W    = 1 + 2 + CTRL_BITS;

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline stage register for a control bundle.
// Priority: reset > hold > load bubble > load data. A bubble is all zeros,
// which is also the reset value, so a reset stage is indistinguishable
// from one that captured a bubble.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Stage register: reset/bubble clear to zero, hold freezes contents
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_q <= '0;
      end else begin
        r_q <= i_d;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decode control bits through ID/EX, EX/MEM and MEM/WB,
// inserts load-use bubbles and squashes wrong-path work on a MEM redirect.
// Optional operand forwarding selects are built only when CTRL_PIPE_FWD_EN
// is defined; otherwise fwd_a/fwd_b are tied to the register-file select.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_branch,
  input  logic                id_jump,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_2_reg,
  input  logic                id_reg_write,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                stall_ext,
  input  logic                mem_redirect,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]   ex_rs1,
  output logic [REG_AW-1:0]   ex_rs2,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                mem_valid,
  output logic                mem_branch,
  output logic                mem_jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic [REG_AW-1:0]   mem_rd,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic                wb_mem_2_reg,
  output logic [REG_AW-1:0]   wb_rd,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  localparam int IDEX_W  = 1 + ALU_OP_W + CTRL_BITS + 3 * REG_AW;
  localparam int EXMEM_W = 1 + 6 + REG_AW;
  localparam int MEMWB_W = 1 + 2 + REG_AW;

  // ---------------- ID -> ID/EX ----------------
  logic [IDEX_W-1:0] w_idex_d;
  logic [IDEX_W-1:0] w_idex_q;
  logic              w_hazard;
  logic              w_idex_bubble;

  // An invalid ID slot enters EX as a pure bubble, whatever decode drives
  assign w_idex_d = id_valid ?
                    {1'b1, id_alu_op, id_alu_src, id_branch, id_jump,
                     id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write,
                     id_rs1, id_rs2, id_rd} : '0;

  assign w_idex_bubble = mem_redirect | w_hazard;

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (stall_ext),
    .i_bubble (w_idex_bubble),
    .i_d      (w_idex_d),
    .o_q      (w_idex_q)
  );

  logic                w_ex_valid;
  logic [ALU_OP_W-1:0] w_ex_alu_op;
  logic                w_ex_alu_src;
  logic                w_ex_branch;
  logic                w_ex_jump;
  logic                w_ex_mem_read;
  logic                w_ex_mem_write;
  logic                w_ex_mem_2_reg;
  logic                w_ex_reg_write;
  logic [REG_AW-1:0]   w_ex_rs1;
  logic [REG_AW-1:0]   w_ex_rs2;
  logic [REG_AW-1:0]   w_ex_rd;

  assign {w_ex_valid, w_ex_alu_op, w_ex_alu_src, w_ex_branch, w_ex_jump,
          w_ex_mem_read, w_ex_mem_write, w_ex_mem_2_reg, w_ex_reg_write,
          w_ex_rs1, w_ex_rs2, w_ex_rd} = w_idex_q;

  assign ex_valid   = w_ex_valid;
  assign ex_alu_src = w_ex_valid & w_ex_alu_src;
  assign ex_alu_op  = w_ex_valid ? w_ex_alu_op : '0;
  assign ex_rs1     = w_ex_rs1;
  assign ex_rs2     = w_ex_rs2;
  assign ex_rd      = w_ex_rd;

  // Load-use detection: a load in EX whose destination an ID source needs
  always_comb begin
    w_hazard = 1'b0;
    if (id_valid && w_ex_valid && w_ex_mem_read && (w_ex_rd != '0) &&
        ((w_ex_rd == id_rs1) || (w_ex_rd == id_rs2))) begin
      w_hazard = 1'b1;
    end
  end

  // Stall request to IF/ID: a redirect discards the ID instruction anyway,
  // but an external freeze keeps the hazard visible so IF/ID also holds
  always_comb begin
    hazard_stall = 1'b0;
    if (!rst) begin
      if (stall_ext) begin
        hazard_stall = w_hazard;
      end else if (!mem_redirect) begin
        hazard_stall = w_hazard;
      end
    end
  end

  // ---------------- EX -> EX/MEM ----------------
  logic [EXMEM_W-1:0] w_exmem_d;
  logic [EXMEM_W-1:0] w_exmem_q;

  assign w_exmem_d = {w_ex_valid,
                      w_ex_valid & w_ex_branch,
                      w_ex_valid & w_ex_jump,
                      w_ex_valid & w_ex_mem_read,
                      w_ex_valid & w_ex_mem_write,
                      w_ex_valid & w_ex_mem_2_reg,
                      w_ex_valid & w_ex_reg_write,
                      w_ex_rd};

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (stall_ext),
    .i_bubble (mem_redirect),
    .i_d      (w_exmem_d),
    .o_q      (w_exmem_q)
  );

  logic              w_mem_valid;
  logic              w_mem_branch;
  logic              w_mem_jump;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_mem_2_reg;
  logic              w_mem_reg_write;
  logic [REG_AW-1:0] w_mem_rd;

  assign {w_mem_valid, w_mem_branch, w_mem_jump, w_mem_read, w_mem_write,
          w_mem_2_reg, w_mem_reg_write, w_mem_rd} = w_exmem_q;

  assign mem_valid  = w_mem_valid;
  assign mem_branch = w_mem_valid & w_mem_branch;
  assign mem_jump   = w_mem_valid & w_mem_jump;
  assign mem_read   = w_mem_valid & w_mem_read;
  assign mem_write  = w_mem_valid & w_mem_write;
  assign mem_rd     = w_mem_rd;

  // ---------------- MEM -> MEM/WB ----------------
  logic [MEMWB_W-1:0] w_memwb_d;
  logic [MEMWB_W-1:0] w_memwb_q;

  // The branch/jump itself is never squashed, so MEM/WB has no bubble input
  assign w_memwb_d = {w_mem_valid,
                      w_mem_valid & w_mem_reg_write,
                      w_mem_valid & w_mem_2_reg,
                      w_mem_rd};

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (stall_ext),
    .i_bubble (1'b0),
    .i_d      (w_memwb_d),
    .o_q      (w_memwb_q)
  );

  logic              w_wb_valid;
  logic              w_wb_reg_write;
  logic              w_wb_mem_2_reg;
  logic [REG_AW-1:0] w_wb_rd;

  assign {w_wb_valid, w_wb_reg_write, w_wb_mem_2_reg, w_wb_rd} = w_memwb_q;

  assign wb_valid     = w_wb_valid;
  // x0 is hard-wired zero, so a write to it is dropped here
  assign wb_reg_write = w_wb_valid & w_wb_reg_write & (w_wb_rd != '0);
  assign wb_mem_2_reg = w_wb_valid & w_wb_mem_2_reg;
  assign wb_rd        = w_wb_rd;

  // ---------------- operand forwarding ----------------
`ifdef CTRL_PIPE_FWD_EN
  logic w_mem_fwd_ok;
  logic w_wb_fwd_ok;

  assign w_mem_fwd_ok = w_mem_valid & w_mem_reg_write & (w_mem_rd != '0);
  assign w_wb_fwd_ok  = wb_reg_write;

  // Forward selects: the younger MEM result shadows the older WB result
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (w_mem_fwd_ok && (w_mem_rd == w_ex_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (w_wb_fwd_ok && (w_wb_rd == w_ex_rs1)) begin
      fwd_a = FWD_WB;
    end
    if (w_mem_fwd_ok && (w_mem_rd == w_ex_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (w_wb_fwd_ok && (w_wb_rd == w_ex_rs2)) begin
      fwd_b = FWD_WB;
    end
  end
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed-vector bench for ctrl_pipe with hand-computed
// expectations. Forward-select expectations follow CTRL_PIPE_FWD_EN.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_alu_op;
  logic       id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write;
  logic       id_mem_2_reg, id_reg_write;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_ext, mem_redirect;
  logic       hazard_stall;
  logic       ex_valid, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_valid, mem_branch, mem_jump, mem_read, mem_write;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_reg_write, wb_mem_2_reg;
  logic [4:0] wb_rd;
  logic [1:0] fwd_a, fwd_b;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CTRL_PIPE_FWD_EN
  localparam logic [1:0] E_MEM = 2'b10;
  localparam logic [1:0] E_WB  = 2'b01;
`else
  localparam logic [1:0] E_MEM = 2'b00;
  localparam logic [1:0] E_WB  = 2'b00;
`endif

  ctrl_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_alu_op    (id_alu_op),
    .id_alu_src   (id_alu_src),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_mem_2_reg (id_mem_2_reg),
    .id_reg_write (id_reg_write),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .stall_ext    (stall_ext),
    .mem_redirect (mem_redirect),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_alu_src   (ex_alu_src),
    .ex_alu_op    (ex_alu_op),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .mem_valid    (mem_valid),
    .mem_branch   (mem_branch),
    .mem_jump     (mem_jump),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_mem_2_reg (wb_mem_2_reg),
    .wb_rd        (wb_rd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic src,
                       input logic br, input logic jp, input logic mr,
                       input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd);
    id_valid = v;     id_alu_op = op;    id_alu_src = src;
    id_branch = br;   id_jump = jp;      id_mem_read = mr;
    id_mem_write = mw; id_mem_2_reg = m2r; id_reg_write = rw;
    id_rs1 = rs1;     id_rs2 = rs2;      id_rd = rd;
  endtask

  task automatic op_alu_r(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs1, rs2, rd);
  endtask

  task automatic op_load(input logic [4:0] rd, input logic [4:0] rs1);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rs1, 5'd0, rd);
  endtask

  task automatic op_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs1, rs2, 5'd0);
  endtask

  // Invalid slot with every decode bit set: must still enter as a bubble
  task automatic op_nop();
    drive(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1);
  endtask

  task automatic drain();
    op_nop();
    repeat (3) tick();
  endtask

  logic [41:0] all_outs;
  assign all_outs = {hazard_stall, ex_valid, ex_alu_src, ex_alu_op, ex_rs1,
                     ex_rs2, ex_rd, mem_valid, mem_branch, mem_jump, mem_read,
                     mem_write, mem_rd, wb_valid, wb_reg_write, wb_mem_2_reg,
                     wb_rd, fwd_a, fwd_b};

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall_ext = 1'b0; mem_redirect = 1'b0;
    op_alu_r(5'd1, 5'd2, 5'd3);

    // Reset held two cycles with a real ALU_R applied
    tick();
    check_eq("rst_cyc1_outs", all_outs, 0);
    tick();
    check_eq("rst_cyc2_outs", all_outs, 0);
    rst = 1'b0;
    op_alu_r(5'd4, 5'd2, 5'd3);
    #1;
    check_eq("rst_release_ex", ex_valid, 0);
    tick();
    check_eq("first_ex", {ex_valid, ex_alu_op, ex_rs1, ex_rs2, ex_rd},
             {1'b1, 2'b10, 5'd2, 5'd3, 5'd4});
    op_nop();
    tick();
    check_eq("nop_bubble_ex", {ex_valid, ex_alu_src, ex_alu_op, ex_rs1, ex_rs2, ex_rd}, 0);
    drain();

    // Straight-line LOAD then independent ALU_R
    op_load(5'd5, 5'd1);
    tick();
    op_alu_r(5'd8, 5'd6, 5'd7);
    #1;
    check_eq("straight_no_stall", hazard_stall, 0);
    tick();
    check_eq("straight_mem", {mem_valid, mem_read, mem_rd, ex_valid, ex_rd},
             {1'b1, 1'b1, 5'd5, 1'b1, 5'd8});
    op_nop();
    tick();
    check_eq("straight_wb", {wb_valid, wb_reg_write, wb_mem_2_reg, wb_rd, mem_read, mem_rd},
             {1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd8});
    drain();

    // Load-use on rs2
    op_load(5'd5, 5'd1);
    tick();
    op_alu_r(5'd9, 5'd6, 5'd5);
    #1;
    check_eq("lu_stall_on", hazard_stall, 1);
    tick();
    check_eq("lu_bubble", {ex_valid, mem_read, mem_rd}, {1'b0, 1'b1, 5'd5});
    check_eq("lu_stall_off", hazard_stall, 0);
    tick();
    check_eq("lu_resume", {ex_valid, ex_rs2, ex_rd, mem_valid, wb_valid, wb_rd},
             {1'b1, 5'd5, 5'd9, 1'b0, 1'b1, 5'd5});
    drain();

    // Load to x0 never stalls and never writes back
    op_load(5'd0, 5'd1);
    tick();
    op_alu_r(5'd9, 5'd6, 5'd0);
    #1;
    check_eq("lu_rd0_no_stall", hazard_stall, 0);
    tick();
    check_eq("lu_rd0_ex", {ex_valid, ex_rd}, {1'b1, 5'd9});
    op_nop();
    tick();
    check_eq("wb_x0_no_write", {wb_valid, wb_reg_write, wb_mem_2_reg},
             {1'b1, 1'b0, 1'b1});
    drain();

    // Redirect squashes the two younger instructions
    op_branch(5'd1, 5'd2);
    tick();
    op_alu_r(5'd10, 5'd1, 5'd2);
    tick();
    check_eq("redir_branch_mem", {mem_valid, mem_branch}, 2'b11);
    op_alu_r(5'd11, 5'd1, 5'd2);
    mem_redirect = 1'b1;
    tick();
    check_eq("redir_squash", {ex_valid, mem_valid, wb_valid, wb_reg_write},
             {1'b0, 1'b0, 1'b1, 1'b0});
    mem_redirect = 1'b0;
    op_nop();
    tick();
    check_eq("redir_wb_gone1", wb_valid, 0);
    tick();
    check_eq("redir_wb_gone2", wb_valid, 0);
    drain();

    // Redirect outranks a load-use hazard
    op_load(5'd6, 5'd1);
    tick();
    op_alu_r(5'd12, 5'd6, 5'd2);
    mem_redirect = 1'b1;
    #1;
    check_eq("redir_over_hazard", hazard_stall, 0);
    tick();
    check_eq("redir_over_hazard_pipe", {ex_valid, mem_valid}, 2'b00);
    mem_redirect = 1'b0;
    drain();

    // External stall freezes everything, redirect applies afterwards
    op_branch(5'd1, 5'd2);
    tick();
    op_alu_r(5'd12, 5'd1, 5'd2);
    tick();
    op_alu_r(5'd13, 5'd1, 5'd2);
    stall_ext = 1'b1;
    mem_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_frozen%0d", i),
               {hazard_stall, ex_valid, ex_rd, mem_valid, mem_branch, wb_valid},
               {1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0});
    end
    stall_ext = 1'b0;
    tick();
    check_eq("stall_then_squash", {ex_valid, mem_valid, wb_valid, wb_reg_write},
             {1'b0, 1'b0, 1'b1, 1'b0});
    mem_redirect = 1'b0;
    drain();

    // Hazard still reported while externally stalled
    op_load(5'd7, 5'd1);
    tick();
    op_alu_r(5'd16, 5'd7, 5'd2);
    stall_ext = 1'b1;
    #1;
    check_eq("stall_hazard_vis", hazard_stall, 1);
    tick();
    check_eq("stall_hold_load", {ex_valid, ex_alu_src, ex_rd}, {1'b1, 1'b1, 5'd7});
    stall_ext = 1'b0;
    #1;
    check_eq("post_stall_hazard", hazard_stall, 1);
    tick();
    check_eq("post_stall_bubble", {ex_valid, mem_read, mem_rd}, {1'b0, 1'b1, 5'd7});
    tick();
    check_eq("post_stall_resume", {ex_valid, ex_rd}, {1'b1, 5'd16});
    drain();

    // Forwarding: MEM copy wins over WB
    op_alu_r(5'd3, 5'd1, 5'd2);
    tick();
    op_alu_r(5'd3, 5'd4, 5'd5);
    tick();
    op_alu_r(5'd14, 5'd3, 5'd3);
    tick();
    check_eq("fwd_mem_wins", {fwd_a, fwd_b}, {E_MEM, E_MEM});

    // Forwarding: rs1 from WB, rs2 from MEM
    op_alu_r(5'd3, 5'd1, 5'd2);
    tick();
    op_alu_r(5'd20, 5'd4, 5'd5);
    tick();
    op_alu_r(5'd15, 5'd3, 5'd20);
    tick();
    check_eq("fwd_wb_mem", {fwd_a, fwd_b}, {E_WB, E_MEM});

    // Forwarding: x0 never forwarded
    op_alu_r(5'd0, 5'd1, 5'd2);
    tick();
    op_alu_r(5'd0, 5'd4, 5'd5);
    tick();
    op_alu_r(5'd17, 5'd0, 5'd0);
    tick();
    check_eq("fwd_x0", {fwd_a, fwd_b}, 4'b0000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the decode control bundle. Takes the per-instruction control signals produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB stages.
- Delivers each stage the subset of signals it consumes.
- Detects load-use hazards and inserts bubbles.
- Squashes wrong-path instructions when a branch or jump resolves in MEM.

Parameters:
- REG_AW, 5, register address width.
- ALU_OP_W, 2, ALUOp width (00 add, 01 sub, 10 R-type).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  ALU_OP_W  ALUOp from decode
- id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write  in  1 each  decode control bits
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID register fields
- stall_ext  in  1  external freeze, e.g. memory wait
- mem_redirect  in  1  branch taken or jump in MEM, from datapath
- hazard_stall  out  1  freeze PC and IF/ID
- ex_valid, ex_alu_src  out  1 each
- ex_alu_op  out  ALU_OP_W
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each
- mem_valid, mem_branch, mem_jump, mem_read, mem_write  out  1 each
- mem_rd  out  REG_AW
- wb_valid, wb_reg_write, wb_mem_2_reg  out  1 each
- wb_rd  out  REG_AW
- fwd_a, fwd_b  out  2 each  operand forward selects (see Optional Feature)

Behaviour:
- Reset (clk edge with rst=1): every stage register loads a bubble. Bubble = valid 0, all control bits 0, alu_op 00, register fields 0. All outputs read 0 from the next cycle on; hazard_stall=0 during reset.
- Latency: an ID bundle appears at ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Load-use hazard (combinational) asserts when all of these hold:
  - id_valid & ex_valid & ex_mem_read
  - ex_rd != 0
  - ex_rd == id_rs1 or ex_rd == id_rs2
- On hazard: hazard_stall=1, ID/EX loads a bubble, EX/MEM and MEM/WB advance normally. ID is held upstream, so the stall lasts exactly 1 cycle.
- mem_redirect=1: ID/EX and EX/MEM load bubbles; MEM/WB advances normally. hazard_stall is forced 0 that cycle.
- stall_ext=1: all three stage registers hold, overriding mem_redirect and hazard. hazard_stall is still computed so IF/ID also holds. A redirect held across a stall takes effect on the first non-stalled edge.
- Priority, highest first: rst > stall_ext > mem_redirect > hazard > normal advance.
- Stage control bits are forced 0 whenever the corresponding valid=0; a bubble never issues a memory access or write-back.
- wb_reg_write is additionally forced 0 when wb_rd == 0 (x0 is never written).
- id_valid=0: ID/EX captures a bubble regardless of the decode bits.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN
- Defined:
  - fwd_a compares ex_rs1, fwd_b compares ex_rs2.
  - Encoding: 10 = forward from MEM (mem_valid, the MEM-stage write enable, mem_rd != 0 and mem_rd == source register); 01 = forward from WB (same conditions using WB); 00 = register file.
  - MEM wins over WB.
  - The MEM-stage write enable is carried internally in EX/MEM.
- Undefined: fwd_a = fwd_b = 00 constant; no comparators are built. The hazard logic is unchanged.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - opcode constants (ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE)
  - ALUOp encodings
  - FWD_RF/FWD_WB/FWD_MEM constants
  - a control-bundle width constant
- Natural sub-module: ctrl_stage_reg, a width-parameterised register with load-bubble and hold inputs and a synchronous reset to bubble, instantiated three times.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 and ALU_R bits applied -> all outputs 0 and hazard_stall=0 throughout; first real outputs appear 1 cycle after rst falls.
- Straight-line: LOAD rd=5 then ALU_R with rs1=6, rs2=7 -> no stall; the load reaches mem_read=1 at cycle 2 and wb_mem_2_reg=1 with wb_rd=5 at cycle 3.
- Load-use: LOAD rd=5, then ALU_R with rs2=5 -> hazard_stall=1 for exactly 1 cycle and one bubble (ex_valid=0) in EX; same test with rd=0 -> no stall.
- Redirect: BRANCH_EQ followed by two ALU_R instructions; mem_redirect=1 when the branch is in MEM -> both younger instructions never reach wb_valid=1; the branch itself reaches WB with wb_reg_write=0.
- Stall vs redirect: assert stall_ext=1 for 3 cycles while mem_redirect=1 -> all outputs frozen; squash occurs on the first edge after stall_ext falls.
- CTRL_PIPE_FWD_EN: ALU_R rd=3, ALU_R rd=3, then ALU_R with rs1=3 and rs2=3 -> fwd_a = fwd_b = 10 (the MEM copy wins); with rd=0 -> 00. Macro undefined -> always 00.
